// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch: PC register, redirect selection, IF/ID register and fetch counter.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_f,
  input  logic               stall_d,
  input  logic               flush_d,
  input  logic               pcsrc_d,
  input  logic [31:0]        pcbranch_d,
  input  logic               jump_d,
  input  logic [25:0]        instr_index_d,
  output logic [IMEM_AW-1:0] imem_a,
  input  logic [31:0]        imem_rd,
  output logic [31:0]        pc_f,
  output logic [31:0]        instr_d,
  output logic [31:0]        pcplus4_d,
  output logic               valid_d,
  output logic [31:0]        fetch_count
);
  logic [31:0] pcplus4_f, jta, pc_next;
  always_comb begin
    pcplus4_f = pc_f + 32'd4;
    jta       = {pcplus4_d[31:28], instr_index_d, 2'b00};
    pc_next   = jump_d ? jta : pcsrc_d ? (pcbranch_d & ~32'd3) : pcplus4_f;
    imem_a    = pc_f[IMEM_AW+1:2];
  end
  // a stalled decode instruction re-presents its redirect, so dropping it here is safe
  always_ff @(posedge clk or negedge reset)
    if (!reset) pc_f <= RESET_PC;
    else if (!stall_f) pc_f <= pc_next;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      instr_d     <= '0;
      pcplus4_d   <= '0;
      valid_d     <= 1'b0;
      fetch_count <= '0;
    end else if (!stall_d) begin
      instr_d     <= flush_d ? '0 : imem_rd;
      pcplus4_d   <= flush_d ? '0 : pcplus4_f;
      valid_d     <= !flush_d;
      fetch_count <= fetch_count + {31'd0, !flush_d};
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard-driven bench for if_stage with a 64-word behavioural instruction memory.
module tb_if_stage;
  logic        clk = 0, reset = 0;
  logic        stall_f = 0, stall_d = 0, flush_d = 0, pcsrc_d = 0, jump_d = 0;
  logic [31:0] pcbranch_d = 0;
  logic [25:0] instr_index_d = 0;
  logic [5:0]  imem_a;
  logic [31:0] imem_rd, pc_f, instr_d, pcplus4_d, fetch_count;
  logic        valid_d;
  logic [31:0] mem [64];
  int vecs = 0, errs = 0;
  typedef struct {logic [31:0] pc, instr, pc4, cnt; logic v;} exp_t;
  exp_t sb[$];
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_v;

  if_stage dut (.clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pcsrc_d(pcsrc_d), .pcbranch_d(pcbranch_d), .jump_d(jump_d), .instr_index_d(instr_index_d),
    .imem_a(imem_a), .imem_rd(imem_rd), .pc_f(pc_f), .instr_d(instr_d), .pcplus4_d(pcplus4_d),
    .valid_d(valid_d), .fetch_count(fetch_count));

  assign imem_rd = mem[imem_a];
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int i);
    return 32'hC0DE_0000 + i;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_v = 0; m_cnt = 0;
  endtask

  task automatic clear_ctl();
    stall_f = 0; stall_d = 0; flush_d = 0; pcsrc_d = 0; jump_d = 0; pcbranch_d = 0; instr_index_d = 0;
  endtask

  // predict the post-edge state from the current inputs, clock once, then compare
  task automatic step();
    exp_t e;
    logic [31:0] np;
    np = stall_f ? m_pc : jump_d ? {m_pc4[31:28], instr_index_d, 2'b00}
       : pcsrc_d ? {pcbranch_d[31:2], 2'b00} : m_pc + 32'd4;
    if (!stall_d) begin
      m_instr = flush_d ? 32'd0 : mem[m_pc[7:2]];
      m_pc4   = flush_d ? 32'd0 : m_pc + 32'd4;
      m_v     = !flush_d;
      m_cnt   = m_cnt + (flush_d ? 32'd0 : 32'd1);
    end
    m_pc = np;
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.v = m_v; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    vecs += 6;
    if (pc_f !== e.pc) begin errs++; $display("FAIL pc_f: got %h want %h", pc_f, e.pc); end
    if (imem_a !== e.pc[7:2]) begin errs++; $display("FAIL imem_a: got %0d want %0d", imem_a, e.pc[7:2]); end
    if (instr_d !== e.instr) begin errs++; $display("FAIL instr_d: got %h want %h", instr_d, e.instr); end
    if (pcplus4_d !== e.pc4) begin errs++; $display("FAIL pcplus4_d: got %h want %h", pcplus4_d, e.pc4); end
    if (valid_d !== e.v) begin errs++; $display("FAIL valid_d: got %b want %b", valid_d, e.v); end
    if (fetch_count !== e.cnt) begin errs++; $display("FAIL fetch_count: got %0d want %0d", fetch_count, e.cnt); end
  endtask

  task automatic test_reset();
    reset = 0; model_reset(); #2;
    vecs += 5;
    if (pc_f !== 32'h0) begin errs++; $display("FAIL reset_pc: got %h want 0", pc_f); end
    if (imem_a !== 6'd0) begin errs++; $display("FAIL reset_imem_a: got %0d want 0", imem_a); end
    if (instr_d !== 32'h0) begin errs++; $display("FAIL reset_instr: got %h want 0", instr_d); end
    if (valid_d !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", valid_d); end
    if (fetch_count !== 32'h0) begin errs++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
    @(negedge clk); reset = 1;
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 4; i++) begin
      step();
      vecs += 2;
      if (instr_d !== word(i)) begin errs++; $display("FAIL run_word%0d: got %h want %h", i, instr_d, word(i)); end
      if (pcplus4_d !== 32'(4 * (i + 1))) begin errs++; $display("FAIL run_pc4_%0d: got %h want %h", i, pcplus4_d, 4 * (i + 1)); end
    end
    vecs++;
    if (fetch_count !== 32'd4) begin errs++; $display("FAIL run_count: got %0d want 4", fetch_count); end
  endtask

  task automatic test_stall();
    stall_f = 1; stall_d = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      vecs += 3;
      if (pc_f !== 32'h10) begin errs++; $display("FAIL stall_pc: got %h want 10", pc_f); end
      if (instr_d !== word(3)) begin errs++; $display("FAIL stall_instr: got %h want %h", instr_d, word(3)); end
      if (fetch_count !== 32'd4) begin errs++; $display("FAIL stall_count: got %0d want 4", fetch_count); end
    end
    clear_ctl(); step();
    vecs++;
    if (instr_d !== word(4)) begin errs++; $display("FAIL stall_resume: got %h want %h", instr_d, word(4)); end
  endtask

  task automatic test_branch_flush();
    pcsrc_d = 1; pcbranch_d = 32'h2E; flush_d = 1; step();
    vecs += 3;
    if (pc_f !== 32'h2C) begin errs++; $display("FAIL br_pc: got %h want 2c", pc_f); end
    if (instr_d !== 32'h0) begin errs++; $display("FAIL br_bubble: got %h want 0", instr_d); end
    if (valid_d !== 1'b0) begin errs++; $display("FAIL br_valid: got %b want 0", valid_d); end
    clear_ctl(); step();
    vecs++;
    if (instr_d !== word(11)) begin errs++; $display("FAIL br_target: got %h want %h", instr_d, word(11)); end
  endtask

  task automatic test_jump_priority();
    pcsrc_d = 1; pcbranch_d = 32'h1000_0004; step();
    clear_ctl(); step();
    vecs += 2;
    if (pcplus4_d !== 32'h1000_0008) begin errs++; $display("FAIL jp_setup: got %h want 10000008", pcplus4_d); end
    if (instr_d !== word(1)) begin errs++; $display("FAIL jp_alias: got %h want %h", instr_d, word(1)); end
    jump_d = 1; instr_index_d = 26'h000_0005; pcsrc_d = 1; pcbranch_d = 32'h40; step();
    vecs++;
    if (pc_f !== 32'h1000_0014) begin errs++; $display("FAIL jp_target: got %h want 10000014", pc_f); end
    clear_ctl();
  endtask

  task automatic test_stall_flush_wrap();
    logic [31:0] held;
    held = instr_d;
    stall_d = 1; flush_d = 1; step();
    vecs += 2;
    if (valid_d !== 1'b1) begin errs++; $display("FAIL sf_valid: got %b want 1", valid_d); end
    if (instr_d !== held) begin errs++; $display("FAIL sf_hold: got %h want %h", instr_d, held); end
    clear_ctl(); pcsrc_d = 1; pcbranch_d = 32'hFC; step();
    vecs++;
    if (imem_a !== 6'd63) begin errs++; $display("FAIL wrap_63: got %0d want 63", imem_a); end
    clear_ctl(); step();
    vecs += 2;
    if (pc_f !== 32'h100) begin errs++; $display("FAIL wrap_pc: got %h want 100", pc_f); end
    if (imem_a !== 6'd0) begin errs++; $display("FAIL wrap_0: got %0d want 0", imem_a); end
  endtask

  task automatic test_async_reset();
    pcsrc_d = 1; pcbranch_d = 32'h20; step(); clear_ctl();
    #2 reset = 0; model_reset(); #1;
    vecs += 2;
    if (pc_f !== 32'h0) begin errs++; $display("FAIL ar_pc: got %h want 0", pc_f); end
    if (valid_d !== 1'b0) begin errs++; $display("FAIL ar_valid: got %b want 0", valid_d); end
    @(negedge clk); reset = 1;
    step();
    vecs += 2;
    if (instr_d !== word(0)) begin errs++; $display("FAIL ar_word0: got %h want %h", instr_d, word(0)); end
    if (pc_f !== 32'h4) begin errs++; $display("FAIL ar_pc4: got %h want 4", pc_f); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = word(i);
    test_reset();
    test_free_run();
    test_stall();
    test_branch_flush();
    test_jump_priority();
    test_stall_flush_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
